step_dir_decoder: RTL and testbench
===================================

STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 Parameter: POS_MAX, default 16'd24000, upper position limit (inclusive).
REQ-002 Parameter: POS_MIN, default 16'd0, lower position limit (inclusive).
REQ-003 Parameter: IDLE_TIMEOUT, default 16'd50000, clk cycles without a step before coils de-energize.
REQ-004 Port: clk  in  1  system clock; one clock domain, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: enable  in  1  global drive enable; synchronous, not synchronized.
REQ-007 Port: step_in  in  1  asynchronous step pulse from motor controller; rising edge = one step.
REQ-008 Port: dir_in  in  1  asynchronous direction; 0 = increment, 1 = decrement.
REQ-009 Port: half_step  in  1  1 = 8-phase half-step sequence, 0 = full-step; synchronous.
REQ-010 Port: coil  out  4  phase drive {A+, B+, A-, B-}, registered.
REQ-011 Port: position  out  16  current axis position in steps, registered.
REQ-012 Port: limit_hit  out  1  one-cycle pulse when a step is refused at a limit.
REQ-013 Port: energized  out  1  high while state = ENERGIZED.

Function
REQ-014 step_in and dir_in SHALL each pass through a 2-flop synchronizer (s1, s2); step_in SHALL feed a third flop s3; step event = s2 & ~s3.
REQ-015 A step_in rising edge set up before clk edge 1 SHALL update position/coil at edge 3 (3-cycle latency); step_in high and low each must last >= 2 cycles.
REQ-016 Direction for a step event SHALL be the synchronized dir value (dir s2) in the event cycle.
REQ-017 States: DISABLED, ENERGIZED, IDLE; 2-bit encoding, internal.
REQ-018 DISABLED: coil = 4'b0000; step events ignored; enable=1 -> ENERGIZED at next edge.
REQ-019 ENERGIZED: coil = table[phase]; idle counter reaching IDLE_TIMEOUT -> IDLE.
REQ-020 IDLE: coil = 4'b0000; phase and position held; step event -> ENERGIZED, and that step SHALL be applied at the same edge.
REQ-021 enable=0 in any state -> DISABLED at next edge; enable=0 has priority over a simultaneous step event, which is dropped.
REQ-022 Phase index: 3-bit, wraps modulo 8; half_step=1 moves +/-1 per step, half_step=0 moves +/-2 per step.
REQ-023 Phase table: 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
REQ-024 Increment step: if position < POS_MAX, position +1 and phase advances; else no change and limit_hit=1 for one cycle.
REQ-025 Decrement step: if position > POS_MIN, position -1 and phase retreats; else no change and limit_hit=1 for one cycle.
REQ-026 Position SHALL change by exactly 1 per accepted step in both modes; no wrap past POS_MIN/POS_MAX.
REQ-027 Idle counter: 16-bit; cleared on accepted or refused step event and on entry to ENERGIZED; otherwise increments in ENERGIZED, saturates at IDLE_TIMEOUT.
REQ-028 half_step changes SHALL take effect on the next step event; phase index is not realigned.
REQ-029 coil SHALL be registered and change only at the edge that applies a step or changes state; no glitches.

Reset
REQ-030 reset=1 SHALL force at next edge: state DISABLED, coil 0000, position 0, phase 0, limit_hit 0, energized 0, idle counter 0.
REQ-031 reset SHALL set step s1/s2/s3 to 1 and dir s1/s2 to 0, so a step_in held high through reset generates no event.
REQ-032 reset SHALL override enable and step events in the same cycle; reset mid-move discards any in-flight step.

Verification
REQ-033 Reset, enable=1, half_step=1, dir=0, 3 step pulses -> position 3, coil 1000->1100->0100->0110, each 3 edges after its step_in rise.
REQ-034 half_step=0 from phase 0, dir=1, position 5, 2 steps -> position 3, phase 6 then 4, coil 0001 then 0010.
REQ-035 POS_MAX=4, at position 4, dir=0 step -> position stays 4, coil unchanged, limit_hit high exactly 1 cycle; at 0 with dir=1 same.
REQ-036 IDLE_TIMEOUT=10, no steps -> energized falls and coil=0000 after 10 cycles; next step -> ENERGIZED, position +1, coil = table[new phase].
REQ-037 enable deasserted in the same cycle as a step event -> step dropped, position unchanged, coil 0000 next edge.
REQ-038 step_in held high through reset release -> no position change; a later rising edge -> position +1.

Source files
------------

// File: rtl/step_dir_decoder_if.sv
// Command/status bundle between a motion controller and the step/direction decoder.
// The master drives step/direction commands; the slave returns coil drive and position.
interface step_dir_decoder_if;
    logic        enable;
    logic        step_in;
    logic        dir_in;
    logic        half_step;
    logic [3:0]  coil;
    logic [15:0] position;
    logic        limit_hit;
    logic        energized;

    modport master (
        output enable, step_in, dir_in, half_step,
        input  coil, position, limit_hit, energized
    );

    modport slave (
        input  enable, step_in, dir_in, half_step,
        output coil, position, limit_hit, energized
    );
endinterface

// File: rtl/step_dir_decoder.sv
// Step/direction decoder: turns asynchronous step pulses into a bounded axis position
// and a full/half-step coil phase pattern, with idle de-energizing.
module step_dir_decoder #(
    parameter logic [15:0] POS_MAX      = 16'd24000,
    parameter logic [15:0] POS_MIN      = 16'd0,
    parameter logic [15:0] IDLE_TIMEOUT = 16'd50000
) (
    input logic clk,
    input logic reset,
    step_dir_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        DISABLED  = 2'd0,
        ENERGIZED = 2'd1,
        IDLE      = 2'd2
    } state_t;

    state_t      state, stateNext;
    logic        stepS1, stepS2, stepS3;
    logic        dirS1, dirS2;
    logic        stepEvent;
    logic [15:0] posReg, posNext;
    logic [2:0]  phaseReg, phaseNext;
    logic [15:0] idleCnt, idleNext;
    logic [3:0]  coilReg, coilNext;
    logic        limitReg, limitNext;
    logic        applyStep;
    logic [2:0]  stepDelta;

    function automatic logic [3:0] phaseCoil(input logic [2:0] p);
        case (p)
            3'd0:    phaseCoil = 4'b1000;
            3'd1:    phaseCoil = 4'b1100;
            3'd2:    phaseCoil = 4'b0100;
            3'd3:    phaseCoil = 4'b0110;
            3'd4:    phaseCoil = 4'b0010;
            3'd5:    phaseCoil = 4'b0011;
            3'd6:    phaseCoil = 4'b0001;
            default: phaseCoil = 4'b1001;
        endcase
    endfunction

    assign stepEvent = stepS2 & ~stepS3;

    // Next-state and datapath: enable drop wins over any step; a step waking from IDLE is applied at once.
    always_comb begin
        stateNext = state;
        posNext   = posReg;
        phaseNext = phaseReg;
        idleNext  = idleCnt;
        limitNext = 1'b0;
        applyStep = 1'b0;
        stepDelta = bus.half_step ? 3'd1 : 3'd2;

        if (!bus.enable) begin
            stateNext = DISABLED;
            idleNext  = 16'd0;
        end else begin
            case (state)
                DISABLED: begin
                    stateNext = ENERGIZED;
                    idleNext  = 16'd0;
                end
                ENERGIZED: begin
                    if (stepEvent) begin
                        applyStep = 1'b1;
                    end else begin
                        idleNext = (idleCnt >= IDLE_TIMEOUT) ? IDLE_TIMEOUT : idleCnt + 16'd1;
                        if (idleNext == IDLE_TIMEOUT) begin
                            stateNext = IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (stepEvent) begin
                        applyStep = 1'b1;
                        stateNext = ENERGIZED;
                    end
                end
                default: stateNext = DISABLED;
            endcase
        end

        if (applyStep) begin
            idleNext = 16'd0;
            if (!dirS2) begin
                if (posReg < POS_MAX) begin
                    posNext   = posReg + 16'd1;
                    phaseNext = phaseReg + stepDelta;
                end else begin
                    limitNext = 1'b1;
                end
            end else begin
                if (posReg > POS_MIN) begin
                    posNext   = posReg - 16'd1;
                    phaseNext = phaseReg - stepDelta;
                end else begin
                    limitNext = 1'b1;
                end
            end
        end

        coilNext = (stateNext == ENERGIZED) ? phaseCoil(phaseNext) : 4'b0000;
    end

    // Synchronizers and all architectural registers; step flops reset high so a held step is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stepS1   <= 1'b1;
            stepS2   <= 1'b1;
            stepS3   <= 1'b1;
            dirS1    <= 1'b0;
            dirS2    <= 1'b0;
            state    <= DISABLED;
            posReg   <= 16'd0;
            phaseReg <= 3'd0;
            idleCnt  <= 16'd0;
            coilReg  <= 4'b0000;
            limitReg <= 1'b0;
        end else begin
            stepS1   <= bus.step_in;
            stepS2   <= stepS1;
            stepS3   <= stepS2;
            dirS1    <= bus.dir_in;
            dirS2    <= dirS1;
            state    <= stateNext;
            posReg   <= posNext;
            phaseReg <= phaseNext;
            idleCnt  <= idleNext;
            coilReg  <= coilNext;
            limitReg <= limitNext;
        end
    end

    assign bus.coil      = coilReg;
    assign bus.position  = posReg;
    assign bus.limit_hit = limitReg;
    assign bus.energized = (state == ENERGIZED);

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: directed scenarios then random step traffic, every cycle
// compared against a behavioural model of the axis.
module tb_step_dir_decoder;

    localparam int PMAX    = 6;
    localparam int PMIN    = 0;
    localparam int TIMEOUT = 10;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    step_dir_decoder_if bus ();

    step_dir_decoder #(
        .POS_MAX     (16'(PMAX)),
        .POS_MIN     (16'(PMIN)),
        .IDLE_TIMEOUT(16'(TIMEOUT))
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] coilTable [8];
    bit         stepHist [$];
    bit         dirHist [$];
    bit         mOn;
    bit         mAsleep;
    bit         mLimit;
    int         mPos;
    int         mPhase;
    int         mQuiet;

    // Behavioural axis: a step_in rise sampled at edge n takes effect at edge n+2.
    task automatic modelEdge();
        bit ev;
        bit down;
        int delta;
        if (reset) begin
            mOn = 0; mAsleep = 0; mPos = 0; mPhase = 0; mQuiet = 0; mLimit = 0;
            stepHist = '{1, 1, 1};
            dirHist  = '{0, 0, 0};
            return;
        end
        ev     = stepHist[1] && !stepHist[2];
        down   = dirHist[1];
        mLimit = 0;
        if (!bus.enable) begin
            mOn = 0; mAsleep = 0; mQuiet = 0;
        end else if (!mOn) begin
            mOn = 1; mAsleep = 0; mQuiet = 0;
        end else if (ev) begin
            mAsleep = 0;
            mQuiet  = 0;
            delta   = bus.half_step ? 1 : 2;
            if (!down) begin
                if (mPos < PMAX) begin
                    mPos++;
                    mPhase = (mPhase + delta) % 8;
                end else mLimit = 1;
            end else begin
                if (mPos > PMIN) begin
                    mPos--;
                    mPhase = (mPhase + 8 - delta) % 8;
                end else mLimit = 1;
            end
        end else if (!mAsleep) begin
            mQuiet++;
            if (mQuiet >= TIMEOUT) mAsleep = 1;
        end
        stepHist.push_front(bus.step_in);
        void'(stepHist.pop_back());
        dirHist.push_front(bus.dir_in);
        void'(dirHist.pop_back());
    endtask

    task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] expCoil;
        expCoil = (mOn && !mAsleep) ? coilTable[mPhase] : 4'b0000;
        checkValue("coil", 16'(bus.coil), 16'(expCoil));
        checkValue("position", bus.position, 16'(mPos));
        checkValue("limit_hit", 16'(bus.limit_hit), 16'(mLimit));
        checkValue("energized", 16'(bus.energized), 16'(mOn && !mAsleep));
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput();
        end
    endtask

    task automatic applyStimulus(input bit down);
        bus.dir_in  = down;
        bus.step_in = 1'b1;
        cycle(3);
        bus.step_in = 1'b0;
        cycle(3);
    endtask

    initial begin
        int  holdLeft;
        int  holdMax;
        coilTable = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
        errors = 0;
        checks = 0;
        stepHist = '{1, 1, 1};
        dirHist  = '{0, 0, 0};
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.step_in = 1'b0;
        bus.dir_in = 1'b0;
        bus.half_step = 1'b1;
        cycle(2);
        checkValue("reset_position", bus.position, 16'd0);

        $display("[TB] half-step increments up to the upper limit");
        reset = 1'b0;
        bus.enable = 1'b1;
        cycle(1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        checkValue("three_steps_pos", bus.position, 16'd3);
        checkValue("three_steps_coil", 16'(bus.coil), 16'b0110);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        checkValue("at_max_pos", bus.position, 16'd6);
        applyStimulus(1'b0);
        checkValue("refused_pos", bus.position, 16'd6);
        checkValue("refused_coil", 16'(bus.coil), 16'b0001);

        $display("[TB] full-step decrements");
        bus.half_step = 1'b0;
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkValue("full_step_pos", bus.position, 16'd4);
        checkValue("full_step_coil", 16'(bus.coil), 16'b0100);

        $display("[TB] idle timeout and enable dropped against a step");
        cycle(12);
        checkValue("idle_energized", 16'(bus.energized), 16'd0);
        bus.step_in = 1'b1;
        cycle(2);
        bus.enable = 1'b0;
        cycle(2);
        bus.step_in = 1'b0;
        cycle(2);
        checkValue("dropped_pos", bus.position, 16'd4);
        checkValue("dropped_coil", 16'(bus.coil), 16'b0000);
        bus.enable = 1'b1;
        cycle(13);
        applyStimulus(1'b1);
        checkValue("wake_pos", bus.position, 16'd3);
        checkValue("wake_coil", 16'(bus.coil), 16'b1000);

        $display("[TB] step held high through reset");
        bus.step_in = 1'b1;
        reset = 1'b1;
        cycle(2);
        reset = 1'b0;
        cycle(5);
        checkValue("held_step_pos", bus.position, 16'd0);
        bus.step_in = 1'b0;
        cycle(3);
        applyStimulus(1'b0);
        checkValue("post_reset_pos", bus.position, 16'd1);
        checkValue("post_reset_coil", 16'(bus.coil), 16'b0100);

        $display("[TB] random step traffic");
        holdLeft = 2;
        for (int seg = 0; seg < 2; seg++) begin
            holdMax = (seg == 0) ? 4 : 20;
            for (int i = 0; i < 800; i++) begin
                if (holdLeft == 0) begin
                    bus.step_in = ~bus.step_in;
                    holdLeft = $urandom_range(2, holdMax);
                end
                holdLeft--;
                if ($urandom_range(0, 3) == 0) bus.dir_in = $urandom_range(0, 1);
                if ($urandom_range(0, 7) == 0) bus.half_step = $urandom_range(0, 1);
                bus.enable = ($urandom_range(0, 24) != 0);
                reset = ($urandom_range(0, 149) == 0);
                cycle(1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
